pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencer for the five-stage RV32I core. Each cycle it drives the enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers from the hazard inputs: load-use, taken branch, instruction-fetch wait and data-memory wait. It also runs a debug halt handshake that drains the pipeline, and it keeps stall and flush performance counters. It sits in the core top beside the pipeline registers. The top ORs each flush output into the matching register's bubble load.

## Interface
- MEM_TIMEOUT, 255: cycles of continuous data-memory wait before `mem_timeout` sets.
- DRAIN_CYCLES, 4: advancing cycles needed to empty IF/ID through MEM/WB.

Ports:
- clk  in  1  core clock.
- rstn  in  1  reset, synchronous, active-low.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads that source.
- ex_rd  in  5  destination register in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  EX redirects the PC this cycle.
- imem_ready  in  1  the fetch word is valid this cycle.
- dmem_req, dmem_ready  in  1 each  MEM-stage access, and its completion.
- halt_req  in  1  debug halt request (level).
- halt_ack  out  1  pipeline empty and frozen.
- pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable  out  1 each.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP) into the register.
- mem_timeout  out  1  sticky error flag.
- stall_cnt, flush_cnt  out  32 each  performance counters.

## Operation
- FSM states: RUN, DRAIN, HALTED. The state is registered; all enable and flush outputs are combinational from the state and the inputs.
- mem_freeze = dmem_req & !dmem_ready. It is orthogonal to the FSM and has the highest priority in every state.
  - While mem_freeze, all five enables are 0 and mem_wb_flush is 1.
  - The state does not advance during mem_freeze.
- load_use = ex_mem_read & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- RUN, without mem_freeze, resolved in priority order:
  - ex_branch_taken: all enables 1; if_id_flush = id_ex_flush = 1.
  - load_use: pc_enable = if_id_enable = 0; id_ex_flush = 1; all other enables 1.
  - !imem_ready: pc_enable = 0; if_id_flush = 1; all other enables 1.
  - Otherwise: all enables 1 and no flush.
- RUN to DRAIN: on halt_req when mem_freeze is 0. The drain counter loads 0.
- DRAIN:
  - Fetch is stopped: if_id_flush = 1, and pc_enable = ex_branch_taken so a resolving branch target is still captured.
  - Branch and load-use rules apply to the downstream registers exactly as in RUN.
  - The counter increments on each non-freeze cycle. Go to HALTED when it reaches DRAIN_CYCLES-1.
  - If halt_req drops during DRAIN, the FSM still completes the drain and goes to HALTED.
- HALTED:
  - All enables 0, no flushes, halt_ack = 1.
  - Go to RUN on the first cycle with halt_req = 0. halt_ack falls in that same transition.
- mem_timeout:
  - A wait counter increments on each mem_freeze cycle and clears on any non-freeze cycle.
  - mem_timeout sets when the counter equals MEM_TIMEOUT-1 while still frozen. It stays set until reset.
  - The counter saturates.
- stall_cnt increments on each cycle with pc_enable = 0 and state other than HALTED.
- flush_cnt increments on each cycle with ex_branch_taken = 1 and mem_freeze = 0.
- Both counters wrap modulo 2^32.

## Timing
- Reset (rstn low at a clk edge):
  - state RUN; drain counter, wait counter, stall_cnt, flush_cnt and mem_timeout all 0; halt_ack 0.
  - While rstn is low, every enable and flush output is 0.
- Zero-cycle latency from hazard inputs to enable/flush outputs.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in MEM and ex_mem_read belongs to the bubble.
- Branch taken together with load_use: the branch wins, and the dependent instruction is flushed.
- Branch taken together with mem_freeze: freeze wins. The branch is re-presented because EX holds.
- halt_req rising during mem_freeze: the RUN to DRAIN transition is taken on the first non-freeze cycle.
- Minimum halt_req to halt_ack: DRAIN_CYCLES+1 cycles with no freeze.
- Reset asserted mid-drain or mid-freeze: the next cycle is RUN with all counters cleared.

## Structure
- pipe_ctrl_pkg:
  - state enum {RUN, DRAIN, HALTED}.
  - REG_X0 constant.
  - counter width constant (32).
- Sub-module pipe_hazard_detect: purely combinational load_use compare. It is reused by the forwarding unit later.
- Counters and FSM live in pipe_ctrl.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle with pc_enable=0, if_id_enable=0, id_ex_flush=1; stall_cnt becomes 1.
- Same case with ex_rd=0 -> no stall.
- Branch taken together with load_use -> if_id_flush=id_ex_flush=1, pc_enable=1; flush_cnt increments by 1.
- dmem_req=1, dmem_ready=0 for 3 cycles -> all enables 0 and mem_wb_flush=1 for those 3 cycles; normal operation on the 4th.
- dmem_req=1, dmem_ready=0 held for 255 cycles -> mem_timeout=1 from cycle 255 on, still 1 after dmem_ready.
- halt_req raised in RUN with no stalls -> halt_ack=1 five cycles later.
  - if_id_flush=1 throughout DRAIN.
  - A branch during DRAIN gives pc_enable=1 for that cycle.
  - halt_req dropped -> RUN with halt_ack=0 on the next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Control bundle order matches the top-level enable/flush ports.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_fl;
    logic id_ex_fl;
    logic mem_wb_fl;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0
  };

  localparam ctrl_t CTRL_GO = '{
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
    1'b0, 1'b0, 1'b0
  };

  localparam ctrl_t CTRL_FREEZE = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b1
  };

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use compare between the ID sources and the EX load destination.
// Pure combinational; shared with the forwarding unit.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1_i
                && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_use_rs2_i
                && (id_rs2_i == ex_rd_i);

  assign load_use_o = ex_mem_read_i
                   && (ex_rd_i != REG_X0)
                   && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: enables/flushes, debug halt drain,
// data-memory wait watchdog and stall/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             halt_ack,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [WAIT_W-1:0] WAIT_HIT =
    WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [DRN_W-1:0] DRN_LAST =
    DRN_W'(DRAIN_CYCLES - 1);

  state_e              state_q, state_d;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                tmo_q, tmo_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    flush_q, flush_d;
  logic                load_use;
  logic                mem_freeze;
  ctrl_t               ctrl;

  pipe_hazard_detect u_hazard (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .load_use_o    (load_use)
  );

  assign mem_freeze = dmem_req && !dmem_ready;

  always_comb begin
    ctrl    = CTRL_IDLE;
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN, DRAIN: begin
        ctrl = CTRL_GO;
        priority case (1'b1)
          ex_branch_taken: begin
            ctrl.if_id_fl = 1'b1;
            ctrl.id_ex_fl = 1'b1;
          end
          load_use: begin
            ctrl.pc_en    = 1'b0;
            ctrl.if_id_en = 1'b0;
            ctrl.id_ex_fl = 1'b1;
          end
          !imem_ready: begin
            ctrl.pc_en    = 1'b0;
            ctrl.if_id_fl = 1'b1;
          end
          default: ;
        endcase
        // Fetch is shut off while draining; only a branch target is taken.
        if (state_q == DRAIN) begin
          ctrl.if_id_fl = 1'b1;
          ctrl.pc_en    = ex_branch_taken;
          drain_d       = drain_q + 1'b1;
          if (drain_q == DRN_LAST) state_d = HALTED;
        end else if (halt_req) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      HALTED: begin
        if (!halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (mem_freeze) begin
      ctrl    = CTRL_FREEZE;
      state_d = state_q;
      drain_d = drain_q;
    end
  end

  always_comb begin
    wait_d = '0;
    if (mem_freeze) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q
                                    : wait_q + 1'b1;
    end
    tmo_d   = tmo_q
           || (mem_freeze && (wait_q == WAIT_HIT));
    stall_d = stall_q + CNT_W'(!ctrl.pc_en
                            && (state_q != HALTED));
    flush_d = flush_q + CNT_W'(ex_branch_taken
                            && !mem_freeze);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= RUN;
      drain_q <= '0;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign pc_enable     = rstn && ctrl.pc_en;
  assign if_id_enable  = rstn && ctrl.if_id_en;
  assign id_ex_enable  = rstn && ctrl.id_ex_en;
  assign ex_mem_enable = rstn && ctrl.ex_mem_en;
  assign mem_wb_enable = rstn && ctrl.mem_wb_en;
  assign if_id_flush   = rstn && ctrl.if_id_fl;
  assign id_ex_flush   = rstn && ctrl.id_ex_fl;
  assign mem_wb_flush  = rstn && ctrl.mem_wb_fl;
  assign halt_ack      = rstn && (state_q == HALTED);
  assign mem_timeout   = tmo_q;
  assign stall_cnt     = stall_q;
  assign flush_cnt     = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard/halt/timeout cases and
// random traffic, compared each cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int MEM_TIMEOUT  = 255;
  localparam int DRAIN_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_mem_read, ex_branch_taken;
  logic        imem_ready, dmem_req, dmem_ready;
  logic        halt_req;
  logic        halt_ack, mem_timeout;
  logic        pc_enable, if_id_enable, id_ex_enable;
  logic        ex_mem_enable, mem_wb_enable;
  logic        if_id_flush, id_ex_flush, mem_wb_flush;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit          m_halted;
  int          m_drain_left;
  int          m_freeze_run;
  bit          m_timeout;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .halt_req        (halt_req),
    .halt_ack        (halt_ack),
    .pc_enable       (pc_enable),
    .if_id_enable    (if_id_enable),
    .id_ex_enable    (id_ex_enable),
    .ex_mem_enable   (ex_mem_enable),
    .mem_wb_enable   (mem_wb_enable),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_flush    (mem_wb_flush),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  function automatic bit m_freeze();
    return dmem_req && !dmem_ready;
  endfunction

  function automatic bit m_load_use();
    bit h1, h2;
    h1 = id_use_rs1 && id_rs1 == ex_rd;
    h2 = id_use_rs2 && id_rs2 == ex_rd;
    return ex_mem_read && ex_rd != 0 && (h1 || h2);
  endfunction

  // {pc, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
  //  if_id_fl, id_ex_fl, mem_wb_fl}
  function automatic logic [7:0] m_ctrl();
    bit pc, ie, fi, fe, lu;
    if (!rstn) return 8'h00;
    if (m_freeze()) return 8'b0000_0001;
    if (m_halted) return 8'h00;
    lu = m_load_use();
    if (ex_branch_taken) begin
      pc = 1; ie = 1; fi = 1; fe = 1;
    end else if (lu) begin
      pc = 0; ie = 0; fi = 0; fe = 1;
    end else if (!imem_ready) begin
      pc = 0; ie = 1; fi = 1; fe = 0;
    end else begin
      pc = 1; ie = 1; fi = 0; fe = 0;
    end
    if (m_drain_left > 0) begin
      fi = 1;
      pc = ex_branch_taken;
    end
    return {pc, ie, 3'b111, fi, fe, 1'b0};
  endfunction

  task automatic m_update(input bit pc);
    bit fz;
    fz = m_freeze();
    if (!rstn) begin
      m_halted     = 0;
      m_drain_left = 0;
      m_freeze_run = 0;
      m_timeout    = 0;
      m_stall      = 0;
      m_flush      = 0;
      return;
    end
    if (!pc && !m_halted) m_stall = m_stall + 1;
    if (ex_branch_taken && !fz) m_flush = m_flush + 1;
    m_freeze_run = fz ? m_freeze_run + 1 : 0;
    if (m_freeze_run >= MEM_TIMEOUT) m_timeout = 1;
    if (fz) return;
    if (m_halted) begin
      if (!halt_req) m_halted = 0;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else if (halt_req) begin
      m_drain_left = DRAIN_CYCLES;
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    logic [7:0] g;
    @(negedge clk);
    e = m_ctrl();
    g = {pc_enable, if_id_enable, id_ex_enable,
         ex_mem_enable, mem_wb_enable,
         if_id_flush, id_ex_flush, mem_wb_flush};
    check("ctrl", {24'd0, g}, {24'd0, e});
    check("halt_ack", {31'd0, halt_ack},
          {31'd0, rstn && m_halted});
    check("mem_timeout", {31'd0, mem_timeout},
          {31'd0, m_timeout});
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
    @(posedge clk);
    m_update(e[7]);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; ex_branch_taken = 0;
    imem_ready = 1; dmem_req = 0; dmem_ready = 0;
    halt_req = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    tick();
    tick();
    rstn = 1;
  endtask

  initial begin
    idle();
    rstn = 0;
    m_update(1'b1);
    @(posedge clk);
    #1;
    do_reset();

    // load-use: one stall cycle
    ex_mem_read = 1; ex_rd = 5;
    id_rs1 = 5; id_use_rs1 = 1;
    tick();
    check("lu_stall_cnt", stall_cnt, 32'd1);
    // same with x0 destination: no stall
    ex_rd = 0; id_rs1 = 0;
    tick();
    // branch beats load-use
    ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    ex_branch_taken = 1;
    tick();
    check("br_flush_cnt", flush_cnt, 32'd1);
    idle();
    // three-cycle data-memory freeze, with a branch held
    dmem_req = 1; ex_branch_taken = 1;
    repeat (3) tick();
    dmem_ready = 1;
    tick();
    idle();
    // halt handshake, branch inside drain
    halt_req = 1;
    tick();
    tick();
    ex_branch_taken = 1;
    tick();
    ex_branch_taken = 0;
    tick();
    tick();
    check("halt_latency", {31'd0, halt_ack}, 32'd1);
    tick();
    halt_req = 0;
    tick();
    tick();
    // halt request raised during freeze
    dmem_req = 1; halt_req = 1;
    repeat (2) tick();
    dmem_req = 0;
    repeat (7) tick();
    idle();
    tick();
    // long freeze trips the watchdog
    dmem_req = 1;
    repeat (MEM_TIMEOUT + 2) tick();
    dmem_ready = 1;
    tick();
    tick();
    check("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
    idle();
    do_reset();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      imem_ready = ($urandom_range(0, 4) != 0);
      dmem_req = ($urandom_range(0, 2) == 0);
      dmem_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 14) == 0) halt_req = !halt_req;
      rstn = ($urandom_range(0, 199) != 0);
      tick();
    end
    rstn = 1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
